scalu_rs: RTL and testbench
===========================

SCALU_RS -- requirements
Module: scalu_rs

Interface
REQ-001 Parameter: DEPTH, default 8, number of reservation-station entries (power of 2, 2..16).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
REQ-003 Dispatch ports SHALL be as follows:
  - dispatch_valid  in  1  new ALU micro-op present
  - dispatch_op  in  5  ALU opcode, scalu encoding
  - dispatch_robid  in  8  ROB id of micro-op
  - dispatch_rd  in  6  destination register
  - dispatch_op1_rdy  in  1  op1 holds value (1) or producer tag (0)
  - dispatch_op1  in  32  value, or tag in [7:0]
  - dispatch_op2_rdy  in  1  same for op2
  - dispatch_op2  in  32  same for op2
  - dispatch_stall  out  1  station full, dispatch not accepted
REQ-004 Wakeup ports SHALL be as follows:
  - wb_valid  in  1  result broadcast
  - wb_robid  in  8  producer tag
  - wb_result  in  32  producer value
REQ-005 Issue ports SHALL be as follows:
  - exers_scalu_issue  out  1  op issued this cycle
  - exers_scalu_op  out  5  opcode
  - exers_robid  out  8  ROB id
  - exers_rd  out  6  destination register
  - exers_op1  out  32  operand 1
  - exers_op2  out  32  operand 2
  - scalu_stall  in  1  ALU cannot accept
  - rob_flush  in  1  pipeline flush

Function
REQ-006 Entry fields SHALL be: valid, op, robid, rd, and per operand rdy plus 32-bit value/tag.
REQ-007 dispatch_stall SHALL be 1 iff all DEPTH entries are valid (registered state); it SHALL NOT use same-cycle issue credit.
REQ-008 Dispatch accept (dispatch_valid & ~dispatch_stall & ~rob_flush) SHALL write the lowest-index free entry at the clock edge.
REQ-009 A dispatched operand with rdy=0 whose tag equals wb_robid while wb_valid is high in the same cycle SHALL be written with wb_result and rdy=1.
REQ-010 Each cycle, every valid entry operand with rdy=0 whose tag matches wb_robid under wb_valid SHALL capture wb_result and set rdy at the edge.
REQ-011 An entry is ready when valid and both operands are rdy, using registered state only; wakeup-to-issue latency SHALL be 1 cycle minimum.
REQ-012 exers_scalu_issue SHALL be (any ready entry) & ~scalu_stall, combinational from state.
REQ-013 Issue data outputs SHALL carry the selected entry and SHALL be 0 when exers_scalu_issue=0.
REQ-014 The issued entry SHALL be freed at the same edge; while scalu_stall=1 no entry is freed and all contents are held.
REQ-015 Dispatch and issue in the same cycle SHALL both take effect; a freed slot becomes visible to dispatch_stall next cycle.
REQ-016 rob_flush SHALL invalidate all entries at the edge, dropping any same-cycle dispatch and wakeup.
REQ-017 Dispatch-to-issue latency SHALL be 1 cycle minimum, for both operands ready at dispatch and no stall.

Reset
REQ-018 rst SHALL clear all valid bits; after reset exers_scalu_issue=0, all issue data outputs=0, and dispatch_stall=0.
REQ-019 rst SHALL take priority over dispatch, wakeup and rob_flush in the same cycle.

Configuration
REQ-020 Macro SCALU_RS_OLDEST_FIRST_EN, when defined, SHALL select the oldest ready entry by dispatch order, tracked with an age matrix updated on dispatch and free.
REQ-021 When SCALU_RS_OLDEST_FIRST_EN is undefined, selection SHALL be the lowest-index ready entry and no age state SHALL exist.

Structure
REQ-022 A shared package SHALL hold XLEN=32, ROBID_W=8, RD_W=6, OP_W=5 and the entry struct typedef.
REQ-023 One sub-module, scalu_rs_select, SHALL implement ready-vector to one-hot grant, either age-based or priority-based according to REQ-020/021.

Verification
REQ-024 Dispatch op=ADD, robid=3, op1=5 rdy, op2=7 rdy -> next cycle issue=1, robid=3, op1=5, op2=7.
REQ-025 Dispatch with op2 tag 9 not ready; broadcast wb_robid=9, wb_result=0x10 at cycle 2 -> issue at cycle 3 with op2=0x10, not earlier.
REQ-026 Fill 8 entries with unready operands -> dispatch_stall=1; 9th dispatch ignored; wakeup of one entry -> stall drops the cycle after its issue.
REQ-027 Hold scalu_stall=1 with ready entries for 4 cycles -> issue=0, contents held; release -> issue resumes.
REQ-028 rob_flush with 5 valid entries and a concurrent dispatch -> next cycle issue=0, dispatch_stall=0, and no stale entry ever issues.
REQ-029 With SCALU_RS_OLDEST_FIRST_EN, entries in slots 4 then 1 become ready in the same cycle -> slot 4 issues first; without the macro -> slot 1 issues first.

Source files
------------

// File: rtl/scalu_rs_pkg.sv
// scalu_rs_pkg: shared widths, opcode encoding and the reservation-station
// entry record used by the scalar ALU reservation station.
package scalu_rs_pkg;

  localparam int XLEN    = 32;
  localparam int ROBID_W = 8;
  localparam int RD_W    = 6;
  localparam int OP_W    = 5;

  // scalu opcode encoding; the station only carries it, it never decodes it
  typedef enum logic [OP_W-1:0] {
    SCALU_ADD  = 5'd0,
    SCALU_SUB  = 5'd1,
    SCALU_AND  = 5'd2,
    SCALU_OR   = 5'd3,
    SCALU_XOR  = 5'd4,
    SCALU_SLL  = 5'd5,
    SCALU_SRL  = 5'd6,
    SCALU_SRA  = 5'd7,
    SCALU_SLT  = 5'd8,
    SCALU_SLTU = 5'd9
  } scalu_op_e;

  // One station slot. When an operand is not ready its low ROBID_W bits
  // hold the producer tag instead of the value.
  typedef struct packed {
    logic               valid;
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic               op1_rdy;
    logic [XLEN-1:0]    op1;
    logic               op2_rdy;
    logic [XLEN-1:0]    op2;
  } rs_entry_t;

  // An operand captures a broadcast when it still waits and its tag matches.
  function automatic logic tag_hit(input logic               rdy,
                                   input logic [ROBID_W-1:0] tag,
                                   input logic               wb_v,
                                   input logic [ROBID_W-1:0] wb_tag);
    return ~rdy & wb_v & (tag == wb_tag);
  endfunction

endpackage

// File: rtl/scalu_rs_select.sv
// scalu_rs_select: turns the ready vector into a one-hot grant.
// Build option SCALU_RS_OLDEST_FIRST_EN: when defined, grant goes to the
// oldest ready entry in dispatch order using an age matrix; otherwise the
// lowest-index ready entry wins and no age state is kept.
module scalu_rs_select
  import scalu_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
`ifdef SCALU_RS_OLDEST_FIRST_EN
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
`endif
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

`ifdef SCALU_RS_OLDEST_FIRST_EN
  // age_q[i][j] = 1 means entry i was dispatched before entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  // A new entry is younger than every other slot; a freed row is cleared
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (alloc[i] || free[i]) begin
        age_d[i] = '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc[j] && (j != i)) begin
          age_d[i][j] = 1'b1;
        end
      end
    end
  end

  // Age matrix register
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        age_q[i] <= '0;
      end else begin
        age_q[i] <= age_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
    logic [DEPTH-1:0] blocked;

    // Entry gi is blocked by any other ready entry that is older than it
    always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked[j] = (j != gi) && ready[j] && !age_q[gi][j];
      end
    end

    assign grant[gi] = ready[gi] & ~(|blocked);
  end
`else
  // Isolate the lowest set bit of the ready vector
  assign grant = ready & (~ready + {{(DEPTH-1){1'b0}}, 1'b1});
`endif

endmodule

// File: rtl/scalu_rs.sv
// scalu_rs: reservation station in front of the scalar ALU. Holds DEPTH
// micro-ops, wakes operands from the result broadcast and issues one ready
// op per cycle. Build option SCALU_RS_OLDEST_FIRST_EN selects oldest-first
// issue instead of lowest-index-first.
module scalu_rs
  import scalu_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  // dispatch
  input  logic               dispatch_valid,
  input  logic [OP_W-1:0]    dispatch_op,
  input  logic [ROBID_W-1:0] dispatch_robid,
  input  logic [RD_W-1:0]    dispatch_rd,
  input  logic               dispatch_op1_rdy,
  input  logic [XLEN-1:0]    dispatch_op1,
  input  logic               dispatch_op2_rdy,
  input  logic [XLEN-1:0]    dispatch_op2,
  output logic               dispatch_stall,
  // wakeup broadcast
  input  logic               wb_valid,
  input  logic [ROBID_W-1:0] wb_robid,
  input  logic [XLEN-1:0]    wb_result,
  // issue
  output logic               exers_scalu_issue,
  output logic [OP_W-1:0]    exers_scalu_op,
  output logic [ROBID_W-1:0] exers_robid,
  output logic [RD_W-1:0]    exers_rd,
  output logic [XLEN-1:0]    exers_op1,
  output logic [XLEN-1:0]    exers_op2,
  input  logic               scalu_stall,
  input  logic               rob_flush
);

  rs_entry_t entries_q [DEPTH];
  rs_entry_t entries_d [DEPTH];
  rs_entry_t disp_entry;

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] alloc_vec;
  logic [DEPTH-1:0] grant_vec;
  logic [DEPTH-1:0] issue_vec;
  logic             dispatch_accept;

  logic [OP_W-1:0]    sel_op;
  logic [ROBID_W-1:0] sel_robid;
  logic [RD_W-1:0]    sel_rd;
  logic [XLEN-1:0]    sel_op1;
  logic [XLEN-1:0]    sel_op2;

  // Readiness is taken from registered state only, so a wakeup or dispatch
  // becomes issuable one cycle after it is captured.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_status
    assign valid_vec[gi] = entries_q[gi].valid;
    assign ready_vec[gi] = entries_q[gi].valid & entries_q[gi].op1_rdy
                         & entries_q[gi].op2_rdy;
  end

  // Full is judged on registered valid bits; a slot freed by this cycle's
  // issue is only offered to dispatch next cycle.
  assign dispatch_stall  = &valid_vec;
  assign dispatch_accept = dispatch_valid & ~dispatch_stall & ~rob_flush;
  assign free_vec        = ~valid_vec;
  assign alloc_vec       = (free_vec & (~free_vec + {{(DEPTH-1){1'b0}}, 1'b1}))
                         & {DEPTH{dispatch_accept}};

  scalu_rs_select #(
    .DEPTH (DEPTH)
  ) u_select (
`ifdef SCALU_RS_OLDEST_FIRST_EN
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc_vec),
    .free  (issue_vec),
`endif
    .ready (ready_vec),
    .grant (grant_vec)
  );

  assign exers_scalu_issue = (|ready_vec) & ~scalu_stall;
  assign issue_vec         = grant_vec & {DEPTH{exers_scalu_issue}};

  // Build the incoming entry, catching a broadcast that lands the same cycle
  always_comb begin
    disp_entry.valid   = 1'b1;
    disp_entry.op      = dispatch_op;
    disp_entry.robid   = dispatch_robid;
    disp_entry.rd      = dispatch_rd;
    disp_entry.op1_rdy = dispatch_op1_rdy;
    disp_entry.op1     = dispatch_op1;
    disp_entry.op2_rdy = dispatch_op2_rdy;
    disp_entry.op2     = dispatch_op2;
    if (tag_hit(dispatch_op1_rdy, dispatch_op1[ROBID_W-1:0], wb_valid, wb_robid)) begin
      disp_entry.op1_rdy = 1'b1;
      disp_entry.op1     = wb_result;
    end
    if (tag_hit(dispatch_op2_rdy, dispatch_op2[ROBID_W-1:0], wb_valid, wb_robid)) begin
      disp_entry.op2_rdy = 1'b1;
      disp_entry.op2     = wb_result;
    end
  end

  // One-hot OR mux of the granted entry payload, zeroed when nothing issues
  always_comb begin
    sel_op    = '0;
    sel_robid = '0;
    sel_rd    = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_vec[i]) begin
        sel_op    = sel_op    | entries_q[i].op;
        sel_robid = sel_robid | entries_q[i].robid;
        sel_rd    = sel_rd    | entries_q[i].rd;
        sel_op1   = sel_op1   | entries_q[i].op1;
        sel_op2   = sel_op2   | entries_q[i].op2;
      end
    end
  end

  assign exers_scalu_op = sel_op;
  assign exers_robid    = sel_robid;
  assign exers_rd       = sel_rd;
  assign exers_op1      = sel_op1;
  assign exers_op2      = sel_op2;

  // Per-entry next state: wakeup, free on issue, allocate, then flush
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid &&
          tag_hit(entries_q[i].op1_rdy, entries_q[i].op1[ROBID_W-1:0], wb_valid, wb_robid)) begin
        entries_d[i].op1_rdy = 1'b1;
        entries_d[i].op1     = wb_result;
      end
      if (entries_q[i].valid &&
          tag_hit(entries_q[i].op2_rdy, entries_q[i].op2[ROBID_W-1:0], wb_valid, wb_robid)) begin
        entries_d[i].op2_rdy = 1'b1;
        entries_d[i].op2     = wb_result;
      end
      if (issue_vec[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc_vec[i]) begin
        entries_d[i] = disp_entry;
      end
      if (rob_flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  // Entry storage; reset only needs to clear the valid bits
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        entries_q[i].valid <= 1'b0;
      end else begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: tb/tb_scalu_rs.sv
// tb_scalu_rs: scoreboard bench for scalu_rs. Expected issue records are
// queued as stimulus is driven and compared as the station issues them.
// Honours SCALU_RS_OLDEST_FIRST_EN for the issue-order scenario.
module tb_scalu_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  logic [7:0]  dispatch_robid;
  logic [5:0]  dispatch_rd;
  logic        dispatch_op1_rdy;
  logic [31:0] dispatch_op1;
  logic        dispatch_op2_rdy;
  logic [31:0] dispatch_op2;
  logic        dispatch_stall;
  logic        wb_valid;
  logic [7:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_scalu_issue;
  logic [4:0]  exers_scalu_op;
  logic [7:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        scalu_stall;
  logic        rob_flush;

  typedef struct {
    logic [4:0]  op;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  scalu_rs #(.DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_valid    (dispatch_valid),
    .dispatch_op       (dispatch_op),
    .dispatch_robid    (dispatch_robid),
    .dispatch_rd       (dispatch_rd),
    .dispatch_op1_rdy  (dispatch_op1_rdy),
    .dispatch_op1      (dispatch_op1),
    .dispatch_op2_rdy  (dispatch_op2_rdy),
    .dispatch_op2      (dispatch_op2),
    .dispatch_stall    (dispatch_stall),
    .wb_valid          (wb_valid),
    .wb_robid          (wb_robid),
    .wb_result         (wb_result),
    .exers_scalu_issue (exers_scalu_issue),
    .exers_scalu_op    (exers_scalu_op),
    .exers_robid       (exers_robid),
    .exers_rd          (exers_rd),
    .exers_op1         (exers_op1),
    .exers_op2         (exers_op2),
    .scalu_stall       (scalu_stall),
    .rob_flush         (rob_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    wb_valid       = 1'b0;
  endtask

  task automatic drv_disp(input logic [7:0] robid, input logic [4:0] op, input logic [5:0] rd,
                          input logic r1, input logic [31:0] v1,
                          input logic r2, input logic [31:0] v2);
    dispatch_valid   = 1'b1;
    dispatch_robid   = robid;
    dispatch_op      = op;
    dispatch_rd      = rd;
    dispatch_op1_rdy = r1;
    dispatch_op1     = v1;
    dispatch_op2_rdy = r2;
    dispatch_op2     = v2;
  endtask

  task automatic drv_wb(input logic [7:0] tag, input logic [31:0] val);
    wb_valid  = 1'b1;
    wb_robid  = tag;
    wb_result = val;
  endtask

  task automatic push_exp(input logic [7:0] robid, input logic [4:0] op, input logic [5:0] rd,
                          input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.robid = robid;
    e.op    = op;
    e.rd    = rd;
    e.op1   = v1;
    e.op2   = v2;
    sb.push_back(e);
  endtask

  // Issue monitor: every issued op must be the next scoreboard record,
  // and idle cycles must present all-zero issue data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exers_scalu_issue) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_issue", 96'(exers_scalu_issue), 96'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("iss_robid", 96'(exers_robid), 96'(e.robid));
          check("iss_data", {13'd0, exers_scalu_op, exers_rd, exers_op1, exers_op2},
                {13'd0, e.op, e.rd, e.op1, e.op2});
        end
      end else begin
        check("idle_zero", 96'({exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2}), 96'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rob_flush = 1'b0;
    scalu_stall = 1'b0;
    dispatch_op = '0; dispatch_robid = '0; dispatch_rd = '0;
    dispatch_op1_rdy = 1'b0; dispatch_op1 = '0;
    dispatch_op2_rdy = 1'b0; dispatch_op2 = '0;
    wb_robid = '0; wb_result = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("rst_stall", 96'(dispatch_stall), 96'd0);
    check("rst_issue", 96'(exers_scalu_issue), 96'd0);
    check("rst_data", 96'({exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2}), 96'd0);
    mon_en = 1'b1;

    // Both operands ready: issue the cycle after dispatch
    drv_disp(8'd3, 5'd0, 6'd1, 1'b1, 32'd5, 1'b1, 32'd7);
    push_exp(8'd3, 5'd0, 6'd1, 32'd5, 32'd7);
    check("t1_same_cycle", 96'(exers_scalu_issue), 96'd0);
    tick(); idle();
    check("t1_issue", 96'(exers_scalu_issue), 96'd1);
    check("t1_robid", 96'(exers_robid), 96'd3);
    tick();

    // op2 waits on tag 9, broadcast at cycle 2, issue at cycle 3
    drv_disp(8'd4, 5'd1, 6'd2, 1'b1, 32'd100, 1'b0, 32'd9);
    push_exp(8'd4, 5'd1, 6'd2, 32'd100, 32'h10);
    tick(); idle();
    check("t2_c1_issue", 96'(exers_scalu_issue), 96'd0);
    tick();
    drv_wb(8'd9, 32'h10);
    check("t2_c2_issue", 96'(exers_scalu_issue), 96'd0);
    tick(); idle();
    check("t2_c3_issue", 96'(exers_scalu_issue), 96'd1);
    check("t2_c3_op2", 96'(exers_op2), 96'h10);
    tick();

    // Broadcast lands in the dispatch cycle itself
    drv_disp(8'd90, 5'd2, 6'd3, 1'b1, 32'd1, 1'b0, 32'd91);
    drv_wb(8'd91, 32'h55);
    push_exp(8'd90, 5'd2, 6'd3, 32'd1, 32'h55);
    tick(); idle();
    check("t2b_issue", 96'(exers_scalu_issue), 96'd1);
    check("t2b_op2", 96'(exers_op2), 96'h55);
    tick();

    // Fill all 8 slots with waiting ops; 9th dispatch must be dropped
    for (int i = 0; i < 8; i++) begin
      drv_disp(8'(10 + i), 5'd3, 6'(i), 1'b0, 32'(30 + i), 1'b1, 32'(i));
      check("t3_fill_stall", 96'(dispatch_stall), 96'd0);
      tick();
    end
    idle();
    check("t3_full_stall", 96'(dispatch_stall), 96'd1);
    drv_disp(8'd99, 5'd4, 6'd9, 1'b1, 32'd1, 1'b1, 32'd2);
    tick(); idle();
    check("t3_ninth_stall", 96'(dispatch_stall), 96'd1);
    check("t3_ninth_issue", 96'(exers_scalu_issue), 96'd0);
    drv_wb(8'd35, 32'h1234_0005);
    push_exp(8'd15, 5'd3, 6'd5, 32'h1234_0005, 32'd5);
    tick(); idle();
    check("t3_wake_issue", 96'(exers_scalu_issue), 96'd1);
    check("t3_wake_stall", 96'(dispatch_stall), 96'd1);
    tick();
    check("t3_freed_stall", 96'(dispatch_stall), 96'd0);
    rob_flush = 1'b1;
    tick();
    rob_flush = 1'b0;
    check("t3_flush_stall", 96'(dispatch_stall), 96'd0);

    // ALU stall holds ready entries, then they drain in order
    scalu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_disp(8'(40 + i), 5'd5, 6'(20 + i), 1'b1, 32'(400 + i), 1'b1, 32'(500 + i));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      check("t4_held_issue", 96'(exers_scalu_issue), 96'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      push_exp(8'(40 + i), 5'd5, 6'(20 + i), 32'(400 + i), 32'(500 + i));
    end
    scalu_stall = 1'b0;
    #1;
    check("t4_rel0", 96'(exers_robid), 96'd40);
    tick();
    check("t4_rel1", 96'(exers_robid), 96'd41);
    tick();
    check("t4_rel2", 96'(exers_robid), 96'd42);
    tick();
    check("t4_drained", 96'(exers_scalu_issue), 96'd0);

    // Flush with 5 valid entries and a concurrent dispatch
    scalu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_disp(8'(50 + i), 5'd6, 6'd7, 1'b1, 32'd1, 1'b1, 32'd2);
      tick();
    end
    drv_disp(8'd55, 5'd6, 6'd7, 1'b1, 32'd1, 1'b1, 32'd2);
    rob_flush = 1'b1;
    tick(); idle();
    rob_flush = 1'b0;
    scalu_stall = 1'b0;
    #1;
    check("t5_issue", 96'(exers_scalu_issue), 96'd0);
    check("t5_stall", 96'(dispatch_stall), 96'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_stale", 96'(exers_scalu_issue), 96'd0);
    end

    // Slot 4 dispatched before slot 1; both woken by the same broadcast
    for (int i = 0; i < 4; i++) begin
      drv_disp(8'(60 + i), 5'd7, 6'd8, 1'b0, 32'(70 + i), 1'b1, 32'(i));
      tick();
    end
    drv_disp(8'd64, 5'd7, 6'd8, 1'b0, 32'd80, 1'b1, 32'd4);
    tick(); idle();
    drv_wb(8'd71, 32'hA71);
    push_exp(8'd61, 5'd7, 6'd8, 32'hA71, 32'd1);
    tick(); idle();
    check("t6_slot1_issue", 96'(exers_robid), 96'd61);
    tick();
    drv_disp(8'd65, 5'd7, 6'd8, 1'b0, 32'd80, 1'b1, 32'd5);
    tick(); idle();
    drv_wb(8'd80, 32'hB80);
`ifdef SCALU_RS_OLDEST_FIRST_EN
    push_exp(8'd64, 5'd7, 6'd8, 32'hB80, 32'd4);
    push_exp(8'd65, 5'd7, 6'd8, 32'hB80, 32'd5);
`else
    push_exp(8'd65, 5'd7, 6'd8, 32'hB80, 32'd5);
    push_exp(8'd64, 5'd7, 6'd8, 32'hB80, 32'd4);
`endif
    tick(); idle();
`ifdef SCALU_RS_OLDEST_FIRST_EN
    check("t6_first", 96'(exers_robid), 96'd64);
`else
    check("t6_first", 96'(exers_robid), 96'd65);
`endif
    tick();
    check("t6_second_issue", 96'(exers_scalu_issue), 96'd1);
    tick();
    check("t6_rest_wait", 96'(exers_scalu_issue), 96'd0);
    rob_flush = 1'b1;
    tick();
    rob_flush = 1'b0;
    tick();

    mon_en = 1'b0;
    check("sb_empty", 96'(sb.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
